alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready handshakes on both sides.
// sel=111 runs an iterative shift-add multiply over WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             borrow,
    output logic             carry,
    output logic             equal,
    output logic             less,
    output logic             more
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_c;
    logic                 r_borrow;
    logic                 r_carry;
    logic                 r_equal;
    logic                 r_less;
    logic                 r_more;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_dif;
    logic [WIDTH-1:0]     w_c;
    logic                 w_borrow;
    logic                 w_carry;
    logic                 w_equal;
    logic                 w_less;
    logic                 w_more;
    logic [2*WIDTH-1:0]   w_acc_nx;
    logic [2*WIDTH-1:0]   w_a_ext;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign borrow    = r_borrow;
    assign carry     = r_carry;
    assign equal     = r_equal;
    assign less      = r_less;
    assign more      = r_more;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_dif   = {1'b0, a} - {1'b0, b};
    assign w_a_ext = {{WIDTH{1'b0}}, a};

    always_comb begin
        w_c      = '0;
        w_borrow = 1'b0;
        w_carry  = 1'b0;
        w_equal  = 1'b0;
        w_less   = 1'b0;
        w_more   = 1'b0;
        unique case (sel)
            3'b000: begin
                w_c     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            3'b001: begin
                w_c      = w_dif[WIDTH-1:0];
                w_borrow = (a < b);
            end
            3'b010: w_c = a ^ b;
            3'b011: w_c = a & b;
            3'b100: w_c = ~(a | b);
            3'b101: w_c = ~(a & b);
            3'b110: begin
                w_equal = (a == b);
                w_less  = (a < b);
                w_more  = (a > b);
            end
            3'b111: w_c = '0;
        endcase
    end

    // One partial product per cycle; the first is folded into the accept edge
    assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_borrow    <= 1'b0;
            r_carry     <= 1'b0;
            r_equal     <= 1'b0;
            r_less      <= 1'b0;
            r_more      <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (sel == 3'b111) begin
                            r_acc    <= b[0] ? w_a_ext : '0;
                            r_mcand  <= w_a_ext << 1;
                            r_mplier <= b >> 1;
                            r_cnt    <= CNT_W'(WIDTH - 2);
                            r_state  <= S_MUL;
                        end else begin
                            r_c         <= w_c;
                            r_borrow    <= w_borrow;
                            r_carry     <= w_carry;
                            r_equal     <= w_equal;
                            r_less      <= w_less;
                            r_more      <= w_more;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nx;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == '0) begin
                        r_c         <= w_acc_nx[WIDTH-1:0];
                        r_carry     <= |w_acc_nx[2*WIDTH-1:WIDTH];
                        r_borrow    <= 1'b0;
                        r_equal     <= 1'b0;
                        r_less      <= 1'b0;
                        r_more      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  c;
    logic        borrow;
    logic        carry;
    logic        equal;
    logic        less;
    logic        more;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [2:0]  sel16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] c16;
    logic        borrow16;
    logic        carry16;
    logic        equal16;
    logic        less16;
    logic        more16;

    int n_tot;
    int n_bad;

    alu_seq #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .borrow(borrow), .carry(carry),
        .equal(equal), .less(less), .more(more)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sel(sel16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .c(c16), .borrow(borrow16), .carry(carry16),
        .equal(equal16), .less(less16), .more(more16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags8();
        return {carry, borrow, equal, less, more};
    endfunction

    // Flags packed as {carry, borrow, equal, less, more}
    task automatic run_op(input string tag, input logic [2:0] s,
                          input logic [7:0] xa, input logic [7:0] xb,
                          input int exp_lat, input logic [7:0] exp_c,
                          input logic [4:0] exp_f);
        int  lat;
        logic rdy_ok;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = xa;
        b         = xb;
        sel       = s;
        out_ready = 1'b0;
        lat       = 0;
        rdy_ok    = 1'b1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 8'h5a;
            b        = 8'ha5;
            lat++;
            if (!out_valid && in_ready)
                rdy_ok = 1'b0;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, rdy_ok, 1'b1);
        check({tag, "_c"}, c, exp_c);
        check({tag, "_flags"}, flags8(), exp_f);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done"}, out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic run16(input string tag, input logic [2:0] s,
                         input logic [15:0] xa, input logic [15:0] xb,
                         input int exp_lat, input logic [15:0] exp_c,
                         input logic exp_carry);
        int lat;
        @(negedge clk);
        in_valid16  = 1'b1;
        a16         = xa;
        b16         = xb;
        sel16       = s;
        out_ready16 = 1'b0;
        lat         = 0;
        while (!out_valid16 && lat < 60) begin
            @(posedge clk);
            #1;
            in_valid16 = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_c"}, c16, exp_c);
        check({tag, "_carry"}, carry16, exp_carry);
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done"}, out_valid16, 1'b0);
        out_ready16 = 1'b0;
    endtask

    initial begin
        n_tot       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        sel         = '0;
        out_ready   = 1'b0;
        in_valid16  = 1'b0;
        a16         = '0;
        b16         = '0;
        sel16       = '0;
        out_ready16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ov", out_valid, 1'b0);
        check("rst_ir", in_ready, 1'b1);
        check("rst_c", c, 8'h00);
        check("rst_f", flags8(), 5'b00000);

        run_op("add", 3'b000, 8'hff, 8'h01, 1, 8'h00, 5'b10000);
        run_op("sub", 3'b001, 8'h00, 8'h01, 1, 8'hff, 5'b01000);
        run_op("and", 3'b011, 8'hf0, 8'h3c, 1, 8'h30, 5'b00000);
        run_op("nor", 3'b100, 8'hf0, 8'h3c, 1, 8'h03, 5'b00000);
        run_op("nand", 3'b101, 8'hf0, 8'h3c, 1, 8'hcf, 5'b00000);
        run_op("cmp_eq", 3'b110, 8'h05, 8'h05, 1, 8'h00, 5'b00100);
        run_op("cmp_gt", 3'b110, 8'h06, 8'h05, 1, 8'h00, 5'b00001);
        run_op("cmp_lt", 3'b110, 8'h04, 8'h05, 1, 8'h00, 5'b00010);
        run_op("cmp_00", 3'b110, 8'h00, 8'h00, 1, 8'h00, 5'b00100);
        run_op("mul_0f", 3'b111, 8'h0f, 8'h11, 8, 8'hff, 5'b00000);
        run_op("mul_10", 3'b111, 8'h10, 8'h10, 8, 8'h00, 5'b10000);
        run_op("mul_0", 3'b111, 8'h00, 8'hab, 8, 8'h00, 5'b00000);
        run_op("mul_ff", 3'b111, 8'hff, 8'hff, 8, 8'h01, 5'b10000);

        // Backpressure: result must hold and a second request must wait
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hf0;
        b        = 8'h3c;
        sel      = 3'b010;
        @(posedge clk);
        #1;
        check("bp_ov", out_valid, 1'b1);
        check("bp_c", c, 8'hcc);
        a   = 8'h11;
        b   = 8'h22;
        sel = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_c", c, 8'hcc);
            check("bp_hold_ov", out_valid, 1'b1);
            check("bp_hold_ir", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("bp_xfer_ov", out_valid, 1'b0);
        check("bp_xfer_ir", in_ready, 1'b1);
        check("bp_keep_c", c, 8'hcc);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_once", out_valid, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hff;
        b        = 8'hff;
        sel      = 3'b111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_ov", out_valid, 1'b0);
        check("mrst_c", c, 8'h00);
        check("mrst_f", flags8(), 5'b00000);
        check("mrst_ir", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mrst_nores", out_valid, 1'b0);
        run_op("add_post", 3'b000, 8'h01, 8'h01, 1, 8'h02, 5'b00000);

        run16("w16_add", 3'b000, 16'hffff, 16'h0001, 1, 16'h0000, 1'b1);
        run16("w16_mul", 3'b111, 16'h0100, 16'h0100, 16, 16'h0000, 1'b1);
        run16("w16_mul2", 3'b111, 16'h0123, 16'h0011, 16, 16'h1353, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
